// File: rtl/axis_demux_1to2_pkg.sv
// Shared constants and types for the packet-aware AXI-Stream 1:2 demultiplexer.
// Holds the routing FSM encoding, route identifiers and skid-buffer depth.
package axis_demux_1to2_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic ROUTE_0    = 1'b0;
    localparam logic ROUTE_1    = 1'b1;
    localparam int   SKID_DEPTH = 2;
    localparam int   CNT_W      = 2;

    // A buffer with SKID_DEPTH entries stored can take no further beat.
    function automatic logic fifo_full(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_W'(SKID_DEPTH));
    endfunction

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry skid FIFO for one demux output; entry 0 is always the head, so
// the outputs come straight from registers and empty entries hold zero.
module axis_skid_fifo2
    import axis_demux_1to2_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  dlast,
    input  logic                  pop,
    output logic [CNT_W-1:0]      count,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dlastout,
    output logic                  valid
);

    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [DATA_WIDTH:0]   mem0_r;
    logic [DATA_WIDTH:0]   mem1_r;
    logic [DATA_WIDTH:0]   mem0_nxt_s;
    logic [DATA_WIDTH:0]   mem1_nxt_s;
    logic [DATA_WIDTH:0]   din_s;
    logic                  valid_r;

    assign din_s = {din, dlast};

    // Next entry contents and occupancy for every push/pop combination.
    always_comb begin
        count_nxt_s = count_r;
        mem0_nxt_s  = mem0_r;
        mem1_nxt_s  = mem1_r;
        case ({push, pop})
            2'b10: begin
                count_nxt_s = count_r + 2'd1;
                if (count_r == 2'd0) begin
                    mem0_nxt_s = din_s;
                end else begin
                    mem1_nxt_s = din_s;
                end
            end
            2'b01: begin
                // Shifting up clears the vacated slot so an empty head reads zero.
                count_nxt_s = count_r - 2'd1;
                mem0_nxt_s  = mem1_r;
                mem1_nxt_s  = '0;
            end
            2'b11: begin
                count_nxt_s = count_r;
                if (count_r == 2'd1) begin
                    mem0_nxt_s = din_s;
                end else begin
                    mem0_nxt_s = mem1_r;
                    mem1_nxt_s = din_s;
                end
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // Buffer storage and occupancy registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            count_r <= '0;
            mem0_r  <= '0;
            mem1_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            mem0_r  <= mem0_nxt_s;
            mem1_r  <= mem1_nxt_s;
            valid_r <= (count_nxt_s != 2'd0);
        end
    end

    assign count    = count_r;
    assign dout     = mem0_r[DATA_WIDTH:1];
    assign dlastout = mem0_r[0];
    assign valid    = valid_r;

endmodule

// File: rtl/axis_demux_1to2.sv
// Packet-aware AXI-Stream 1:2 demultiplexer: the route is taken from sel on a
// packet's first beat and held until its TLAST beat is accepted.
module axis_demux_1to2
    import axis_demux_1to2_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [DATA_WIDTH-1:0] DATA_in,
    input  logic                  TVALID_in,
    input  logic                  TLAST_in,
    output logic                  TREADY_in,
    input  logic                  sel,
    output logic [DATA_WIDTH-1:0] DATA_out_0,
    output logic                  TVALID_out_0,
    output logic                  TLAST_out_0,
    input  logic                  TREADY_out_0,
    output logic [DATA_WIDTH-1:0] DATA_out_1,
    output logic                  TVALID_out_1,
    output logic                  TLAST_out_1,
    input  logic                  TREADY_out_1,
    output logic                  pkt_active
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             route_q_r;
    logic             route_q_nxt_s;
    logic             route_s;
    logic             act_r;
    logic             accept_s;
    logic             ready_s;
    logic             push0_s;
    logic             push1_s;
    logic             pop0_s;
    logic             pop1_s;
    logic [CNT_W-1:0] count0_s;
    logic [CNT_W-1:0] count1_s;

    // Route mux and input ready; ready depends only on buffer occupancy,
    // never on the downstream TREADY inputs.
    always_comb begin
        if (state_r == ST_LOCKED) begin
            route_s = route_q_r;
        end else begin
            route_s = sel;
        end
        if (route_s == ROUTE_1) begin
            ready_s = !fifo_full(count1_s);
        end else begin
            ready_s = !fifo_full(count0_s);
        end
    end

    assign TREADY_in = !ARESET && ready_s;
    assign accept_s  = TVALID_in && TREADY_in;
    assign push0_s   = accept_s && (route_s == ROUTE_0);
    assign push1_s   = accept_s && (route_s == ROUTE_1);
    assign pop0_s    = TVALID_out_0 && TREADY_out_0;
    assign pop1_s    = TVALID_out_1 && TREADY_out_1;

    // Routing FSM next state and route latch.
    always_comb begin
        state_nxt_s   = state_r;
        route_q_nxt_s = route_q_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !TLAST_in) begin
                    state_nxt_s   = ST_LOCKED;
                    route_q_nxt_s = sel;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (accept_s && TLAST_in) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched route and registered pkt_active.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r   <= ST_IDLE;
            route_q_r <= ROUTE_0;
            act_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            route_q_r <= route_q_nxt_s;
            act_r     <= (state_nxt_s == ST_LOCKED);
        end
    end

    assign pkt_active = act_r;

    axis_skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo0 (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .push     (push0_s),
        .din      (DATA_in),
        .dlast    (TLAST_in),
        .pop      (pop0_s),
        .count    (count0_s),
        .dout     (DATA_out_0),
        .dlastout (TLAST_out_0),
        .valid    (TVALID_out_0)
    );

    axis_skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo1 (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .push     (push1_s),
        .din      (DATA_in),
        .dlast    (TLAST_in),
        .pop      (pop1_s),
        .count    (count1_s),
        .dout     (DATA_out_1),
        .dlastout (TLAST_out_1),
        .valid    (TVALID_out_1)
    );

endmodule

// File: tb/tb_axis_demux_1to2.sv
// Directed bench for axis_demux_1to2: a vector table for reset, single-beat
// and route-lock traffic, then hand-written back-pressure and reset sequences.
module tb_axis_demux_1to2;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic [7:0] DATA_in;
    logic       TVALID_in;
    logic       TLAST_in;
    logic       TREADY_in;
    logic       sel;
    logic [7:0] DATA_out_0;
    logic       TVALID_out_0;
    logic       TLAST_out_0;
    logic       TREADY_out_0;
    logic [7:0] DATA_out_1;
    logic       TVALID_out_1;
    logic       TLAST_out_1;
    logic       TREADY_out_1;
    logic       pkt_active;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ACLK = ~ACLK;

    axis_demux_1to2 #(.DATA_WIDTH(8)) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .DATA_in      (DATA_in),
        .TVALID_in    (TVALID_in),
        .TLAST_in     (TLAST_in),
        .TREADY_in    (TREADY_in),
        .sel          (sel),
        .DATA_out_0   (DATA_out_0),
        .TVALID_out_0 (TVALID_out_0),
        .TLAST_out_0  (TLAST_out_0),
        .TREADY_out_0 (TREADY_out_0),
        .DATA_out_1   (DATA_out_1),
        .TVALID_out_1 (TVALID_out_1),
        .TLAST_out_1  (TLAST_out_1),
        .TREADY_out_1 (TREADY_out_1),
        .pkt_active   (pkt_active)
    );

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic       v, l, s, r0, r1;
        logic       e_rdy;
        logic       e_v0;
        logic [7:0] e_d0;
        logic       e_l0, e_v1;
        logic [7:0] e_d1;
        logic       e_l1, e_act;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic v0, input logic [7:0] d0, input logic l0,
                            input logic v1, input logic [7:0] d1, input logic l1, input logic act);
        chk({tag, ".v0"}, 32'(TVALID_out_0), 32'(v0));
        chk({tag, ".d0"}, 32'(DATA_out_0), 32'(d0));
        chk({tag, ".l0"}, 32'(TLAST_out_0), 32'(l0));
        chk({tag, ".v1"}, 32'(TVALID_out_1), 32'(v1));
        chk({tag, ".d1"}, 32'(DATA_out_1), 32'(d1));
        chk({tag, ".l1"}, 32'(TLAST_out_1), 32'(l1));
        chk({tag, ".act"}, 32'(pkt_active), 32'(act));
    endtask

    // Drive one beat, check ready before the edge and outputs after it.
    task automatic step(input string tag, input logic [7:0] d, input logic v, input logic l,
                        input logic s, input logic exp_rdy);
        DATA_in = d; TVALID_in = v; TLAST_in = l; sel = s;
        #1;
        chk({tag, ".rdy"}, 32'(TREADY_in), 32'(exp_rdy));
        @(posedge ACLK); #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic [7:0] d, input logic v, input logic l,
                                input logic s, input logic rdy, input logic v0, input logic [7:0] d0,
                                input logic l0, input logic v1, input logic [7:0] d1, input logic l1,
                                input logic act);
        vec_t t;
        t.rst = rst; t.d = d; t.v = v; t.l = l; t.s = s; t.r0 = 1'b1; t.r1 = 1'b1;
        t.e_rdy = rdy; t.e_v0 = v0; t.e_d0 = d0; t.e_l0 = l0;
        t.e_v1 = v1; t.e_d1 = d1; t.e_l1 = l1; t.e_act = act;
        return t;
    endfunction

    initial begin
        int idx;
        int nxt;
        int cyc;
        int beat;

        //            rst   d      v     l     s     rdy   v0    d0     l0    v1    d1     l1    act
        tbl[0]  = mk(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1);
        tbl[11] = mk(1'b0, 8'h13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        ARESET = 1'b1; DATA_in = 8'h00; TVALID_in = 1'b0; TLAST_in = 1'b0; sel = 1'b0;
        TREADY_out_0 = 1'b1; TREADY_out_1 = 1'b1;

        for (int i = 0; i < 13; i++) begin
            ARESET = tbl[i].rst; TREADY_out_0 = tbl[i].r0; TREADY_out_1 = tbl[i].r1;
            step($sformatf("vec%0d", i), tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].s, tbl[i].e_rdy);
            chk_outs($sformatf("vec%0d", i), tbl[i].e_v0, tbl[i].e_d0, tbl[i].e_l0,
                     tbl[i].e_v1, tbl[i].e_d1, tbl[i].e_l1, tbl[i].e_act);
        end

        // Back-pressure: output 0 stalled, only two beats fit.
        TREADY_out_0 = 1'b0;
        step("bp1", 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_outs("bp1", 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step("bp2", 8'h02, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_outs("bp2", 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step("bp3", 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_outs("bp3", 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step("bp4", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);

        // Release the stall and check every beat arrives once, in order.
        TREADY_out_0 = 1'b1;
        idx = 3; nxt = 1; cyc = 0;
        while (nxt <= 5 && cyc < 40) begin
            DATA_in = 8'(idx); TVALID_in = (idx <= 5); TLAST_in = (idx == 5); sel = 1'b1;
            #1;
            if (TVALID_out_0 && TREADY_out_0) begin
                chk("drain.d0", 32'(DATA_out_0), 32'(nxt));
                chk("drain.l0", 32'(TLAST_out_0), 32'(nxt == 5));
                nxt++;
            end
            chk("drain.v1", 32'(TVALID_out_1), 32'd0);
            beat = (TVALID_in && TREADY_in) ? 1 : 0;
            @(posedge ACLK); #1;
            idx += beat;
            cyc++;
        end
        chk("drain.count", 32'(nxt), 32'd6);
        chk_outs("drain.end", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Independent drain: fill output 0, then stream a packet to output 1.
        TREADY_out_0 = 1'b0;
        step("fill1", 8'h21, 1'b1, 1'b0, 1'b0, 1'b1);
        step("fill2", 8'h22, 1'b1, 1'b1, 1'b0, 1'b1);
        chk_outs("fill", 1'b1, 8'h21, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("ind1", 8'h31, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_outs("ind1", 1'b1, 8'h21, 1'b0, 1'b1, 8'h31, 1'b0, 1'b1);
        step("ind2", 8'h32, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_outs("ind2", 1'b1, 8'h21, 1'b0, 1'b1, 8'h32, 1'b0, 1'b1);
        step("ind3", 8'h33, 1'b1, 1'b1, 1'b0, 1'b1);
        chk_outs("ind3", 1'b1, 8'h21, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        step("ind4", 8'h41, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_outs("ind4", 1'b1, 8'h21, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0);
        step("stall0", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_outs("stall0", 1'b1, 8'h21, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        TREADY_out_0 = 1'b1;
        step("rel1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_outs("rel1", 1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("rel2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_outs("rel2", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset mid-packet drops buffered beats and unlocks the route.
        TREADY_out_0 = 1'b0; TREADY_out_1 = 1'b0;
        step("rp1", 8'h51, 1'b1, 1'b0, 1'b0, 1'b1);
        step("rp2", 8'h52, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_outs("rp2", 1'b1, 8'h51, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        ARESET = 1'b1;
        step("rst", 8'h53, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_outs("rst", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        ARESET = 1'b0; TREADY_out_1 = 1'b1;
        step("post", 8'h61, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_outs("post", 1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_demux_1to2.md
Name: axis_demux_1to2

Overview:
- Packet-aware AXI-Stream 1:2 demultiplexer. It is the router counterpart to the team's 2:1 AXIS mux.
- One slave input stream is steered to one of two master output streams.
- The route is latched on the first beat of a packet and held until the TLAST beat is accepted, so packets are never split across outputs.
- Each output has a 2-entry skid buffer. This gives 1-cycle latency and full throughput under continuous TREADY.

Parameters:
- DATA_WIDTH, 8, width of the TDATA path.

Ports:
- ACLK  input  1  clock; all logic on the rising edge.
- ARESET  input  1  synchronous, active-high reset.
- DATA_in  input  DATA_WIDTH  input stream data.
- TVALID_in  input  1  input stream valid.
- TLAST_in  input  1  input stream last beat of packet.
- TREADY_in  output  1  input stream ready.
- sel  input  1  destination select (0 → output 0, 1 → output 1); sampled only at packet start.
- DATA_out_0  output  DATA_WIDTH  output 0 data.
- TVALID_out_0  output  1  output 0 valid.
- TLAST_out_0  output  1  output 0 last.
- TREADY_out_0  input  1  output 0 ready.
- DATA_out_1, TVALID_out_1, TLAST_out_1, TREADY_out_1: same as output 0, for output 1.
- pkt_active  output  1  high while a multi-beat packet is mid-transfer (route locked).

Behaviour:
- Reset (ARESET high at a rising edge):
  - state=IDLE, route_q=0, both buffer counts=0, all buffer entries cleared.
  - All TVALID_out_k, TLAST_out_k, DATA_out_k, pkt_active = 0.
  - TREADY_in is forced 0 combinationally while ARESET is high.
- Reset mid-packet: the partial packet is dropped, buffered beats are discarded, and no TLAST is emitted. This is intended.
- Acceptance: a beat is accepted when TVALID_in && TREADY_in at a rising edge.
- Route select:
  - route = sel when state=IDLE; route = route_q when state=LOCKED.
- Routing FSM (states IDLE, LOCKED):
  - IDLE, beat accepted with TLAST_in=0 → LOCKED; route_q <= sel.
  - IDLE, beat accepted with TLAST_in=1 → stays IDLE (single-beat packet).
  - LOCKED, beat accepted with TLAST_in=1 → IDLE.
  - Any other case holds state.
  - sel changes while LOCKED are ignored.
- pkt_active = (state==LOCKED), driven from a register.
- Handshake: TREADY_in = !ARESET && (count[route] < 2).
  - Combinational from sel only in IDLE. No path from TREADY_out_k to TREADY_in.
  - TVALID_in may assert or deassert freely between beats; mid-packet bubbles do not change state.
- Skid buffer, per output k (2-entry FIFO, count 0..2):
  - Push on an accepted beat with route==k, storing {DATA_in, TLAST_in}.
  - Pop when TVALID_out_k && TREADY_out_k.
  - Push+pop in the same cycle leaves count unchanged and preserves order.
  - Push at count 2 is impossible, because TREADY_in is low.
  - Pop at count 0 is impossible, because TVALID_out_k is low.
- Output drive:
  - TVALID_out_k = (count_k != 0).
  - DATA_out_k and TLAST_out_k show the head entry. Both are driven 0 when count_k = 0.
  - Outputs obey AXIS: once TVALID_out_k is high, DATA/TLAST/TVALID stay stable until the pop.
- Latency: a beat accepted at edge N is visible on the output after edge N (1 cycle).
- Throughput:
  - 1 beat/cycle with TREADY_out_k held high.
  - A stalled output back-pressures the input only while that output is routed.
  - The other output keeps draining independently.
- Back-to-back packets to different outputs: the new sel is taken on the first beat after TLAST, with no idle cycle inserted.

Decomposition:
- Shared package / include:
  - Routing FSM state encoding (ST_IDLE=0, ST_LOCKED=1).
  - Route constants (ROUTE_0=0, ROUTE_1=1).
  - Buffer depth constant SKID_DEPTH=2.
- Sub-module axis_skid_fifo2 (parameter DATA_WIDTH; ports ACLK, ARESET, push, din, dlast, pop, count, dout, dlastout, valid), instantiated once per output.
- The top level holds only the FSM, route mux, and TREADY logic.

Test Plan:
1. Reset + idle: assert ARESET 3 cycles with TVALID_in=1 → TREADY_in=0 throughout; all outputs 0; pkt_active=0; after release TREADY_in=1.
2. Single-beat packets: sel=0, beat 0xA5 TLAST=1 → DATA_out_0=0xA5, TVALID_out_0=1, TLAST_out_0=1 one cycle later; output 1 stays 0; pkt_active never rises.
3. Route lock: sel=1, 4-beat packet 0x10..0x13; sel toggled to 0 after beat 1 → all 4 beats on output 1, TLAST only on 0x13; pkt_active high from after beat 0 to after beat 3.
4. Back-pressure: TREADY_out_0=0, 5-beat packet to output 0 → 2 beats accepted, then TREADY_in=0. Raise TREADY_out_0 → remaining beats flow in order 0x01..0x05, none lost or duplicated.
5. Independent drain: output 0 stalled full, packet on output 1 in flight → next packet with sel=1 flows at 1 beat/cycle; sel=0 packet stalls at TREADY_in=0.
6. Reset mid-packet: ARESET asserted after beat 2 of a 6-beat packet → both buffers empty and state IDLE next cycle; a new packet with sel=1 routes to output 1.
